// File: rtl/mem_resp_ctrl.sv
// -----------------------------------------------------------------------------
// mem_resp_ctrl
//
// Memory-side responder for the CPU memory port. It accepts one request at a
// time over a valid/ready handshake and waits a fixed number of busy cycles.
// At the end of that wait it commits the access against a little-endian,
// byte-addressed store. It then presents a single response that the CPU
// consumes with a ready handshake. Misaligned, out-of-range and illegal-size
// accesses return a fault and leave the store untouched.
//
// Parameters
//   WAIT_CYCLES  extra busy cycles between accept and response (0..15)
//   DEPTH_BYTES  store size in bytes (power of two, multiple of 4)
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   reset       synchronous active-high reset (store contents are kept)
//   req_valid   CPU presents a request
//   req_ready   responder can accept; high only while idle
//   req_write   1 = write, 0 = read
//   req_size    00 word, 01 half, 10 byte, 11 illegal
//   req_addr    byte address
//   req_wdata   right-aligned write data
//   resp_valid  response available
//   resp_ready  CPU consumes the response
//   resp_rdata  zero-extended read data; 0 for writes and faults
//   resp_fault  access faulted; qualified by resp_valid
// -----------------------------------------------------------------------------
module mem_resp_ctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int ADDR_W    = $clog2(DEPTH_BYTES);
  // Each byte lane holds one quarter of the store, indexed by addr[ADDR_W-1:2].
  localparam int ROW_W     = (ADDR_W > 2) ? ADDR_W - 2 : 1;
  localparam int BANK_ROWS = 1 << ROW_W;

  localparam logic [3:0]  WAIT_INIT   = 4'(WAIT_CYCLES);
  localparam logic [32:0] DEPTH_LIMIT = 33'(DEPTH_BYTES);

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic        fault_q, fault_d;

  logic              commit;
  logic              fault_now;
  logic [ROW_W-1:0]  row;
  logic [31:0]       lane_rd;

  // ---------------------------------------------------------------------------
  // Fault classification of the latched request
  // ---------------------------------------------------------------------------
  always_comb begin
    fault_now = 1'b0;
    if (size_q == SZ_ILL)                               fault_now = 1'b1;
    if ({1'b0, addr_q} >= DEPTH_LIMIT)                  fault_now = 1'b1;
    if ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00))  fault_now = 1'b1;
    if ((size_q == SZ_HALF) && addr_q[0])               fault_now = 1'b1;
  end

  // Aligned accesses never straddle a row, so every lane uses the same row.
  assign row = addr_q[ROW_W+1:2];

  // ---------------------------------------------------------------------------
  // Control FSM: next state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    fault_d      = fault_q;
    commit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_INIT;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit       = 1'b1;
          fault_d      = fault_now;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      wr_q         <= 1'b0;
      size_q       <= 2'b00;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      fault_q      <= fault_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_fault = fault_q;

  // ---------------------------------------------------------------------------
  // Storage: four byte-lane banks with registered read ports
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);

      logic [7:0] mem [BANK_ROWS];
      logic       we;
      logic [1:0] src;
      logic [7:0] wd;
      logic [7:0] rd_q;

      // Lane select for the access width and offset.
      always_comb begin
        we = 1'b0;
        case (size_q)
          SZ_WORD: we = 1'b1;
          SZ_HALF: we = (LANE[1] == addr_q[1]);
          SZ_BYTE: we = (LANE == addr_q[1:0]);
          default: we = 1'b0;
        endcase
        we = we & commit & wr_q & ~fault_now;
      end

      // Write data is right-aligned, so this lane takes byte (lane - offset).
      assign src = LANE - addr_q[1:0];
      assign wd  = wdata_q[{src, 3'b000} +: 8];

      // A reset on the commit edge drops the write.
      always_ff @(posedge clk) begin
        if (!reset && we) begin
          mem[row] <= wd;
        end
        if (commit) begin
          rd_q <= mem[row];
        end
      end

      assign lane_rd[8*gi +: 8] = rd_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Response data: the lane registers and latched request are stable in RESP
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_rdata = 32'd0;
    if (resp_valid_q && !fault_q && !wr_q) begin
      case (size_q)
        SZ_WORD: resp_rdata = lane_rd;
        SZ_HALF: resp_rdata = {16'd0, addr_q[1] ? lane_rd[31:16] : lane_rd[15:0]};
        SZ_BYTE: resp_rdata = {24'd0, lane_rd[{addr_q[1:0], 3'b000} +: 8]};
        default: resp_rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for mem_resp_ctrl. It drives two instances, one with
// WAIT_CYCLES=2 and one with WAIT_CYCLES=0. A byte-array reference model
// predicts the fault/rdata of each transaction and the latency.
// -----------------------------------------------------------------------------
module tb_mem_resp_ctrl;

  localparam int W0 = 2;
  localparam int W1 = 0;

  logic        clk = 1'b0;
  logic [1:0]  reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [1:0]  req_size [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready;
  logic [31:0] resp_rdata [2];
  logic [1:0]  resp_fault;

  int n_chk  = 0;
  int n_pass = 0;
  int wait_of [2];

  logic [7:0] mdl [2][256];

  always #5 clk = ~clk;

  mem_resp_ctrl #(.WAIT_CYCLES(W0), .DEPTH_BYTES(256)) u_dut0 (
    .clk(clk), .reset(reset[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_size(req_size[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0])
  );

  mem_resp_ctrl #(.WAIT_CYCLES(W1), .DEPTH_BYTES(256)) u_dut1 (
    .clk(clk), .reset(reset[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_size(req_size[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference model: fault rules and little-endian byte store.
  function automatic void model_txn(input int d, input bit wr, input logic [1:0] sz,
                                    input logic [31:0] a, input logic [31:0] wd,
                                    output bit f, output logic [31:0] rd);
    int n;
    rd = 32'd0;
    f  = (sz == 2'b11) || (a >= 32'd256) ||
         (sz == 2'b00 && (a % 4) != 0) || (sz == 2'b01 && (a % 2) != 0);
    if (f) return;
    n = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      if (wr) mdl[d][int'(a) + i] = wd[8*i +: 8];
      else    rd[8*i +: 8] = mdl[d][int'(a) + i];
    end
  endfunction

  task automatic txn(input int d, input bit wr, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input int hold,
                     output logic [31:0] got_rd, output logic got_f);
    bit          ef;
    logic [31:0] erd;
    logic [31:0] h_rd;
    logic        h_f;
    int          n;
    int          lat;
    model_txn(d, wr, sz, a, wd, ef, erd);
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = wr; req_size[d] = sz;
    req_addr[d] = a; req_wdata[d] = wd; resp_ready[d] = (hold == 0);
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
    @(posedge clk); #1;
    // Scramble request inputs after accept; they must be ignored.
    req_valid[d] = 1'b0; req_write[d] = 1'($urandom); req_size[d] = 2'($urandom);
    req_addr[d] = $urandom; req_wdata[d] = $urandom;
    chk("req_ready_busy", 32'(req_ready[d]), 32'd0);
    lat = 0;
    while (resp_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(wait_of[d] + 1));
    chk("fault", 32'(resp_fault[d]), 32'(ef));
    chk("rdata", resp_rdata[d], erd);
    got_rd = resp_rdata[d];
    got_f  = resp_fault[d];
    h_rd   = resp_rdata[d];
    h_f    = resp_fault[d];
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid[d]), 32'd1);
      chk("hold_rdata", resp_rdata[d], h_rd);
      chk("hold_fault", 32'(resp_fault[d]), 32'(h_f));
      chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
    end
    if (hold > 0) begin
      req_valid[d]  = 1'b0;
      resp_ready[d] = 1'b1;
    end
    @(posedge clk); #1;
    chk("resp_done", 32'(resp_valid[d]), 32'd0);
    chk("idle_ready", 32'(req_ready[d]), 32'd1);
  endtask

  // Reset asserted k edges after accept of a word write; the write must vanish.
  task automatic reset_mid(input int d, input logic [31:0] a, input logic [31:0] wd, input int k);
    int n;
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = 1'b1; req_size[d] = 2'b00;
    req_addr[d] = a; req_wdata[d] = wd; resp_ready[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    repeat (k - 1) @(posedge clk);
    @(negedge clk);
    reset[d] = 1'b1;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid[d]), 32'd0);
    chk("rst_rdata", resp_rdata[d], 32'd0);
    reset[d] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    logic        f;
    bit          ef;
    logic [31:0] erd;
    int          prev;
    int          cnt;

    wait_of[0] = W0;
    wait_of[1] = W1;
    reset = 2'b11; req_valid = 2'b00; req_write = 2'b00; resp_ready = 2'b11;
    for (int d = 0; d < 2; d++) begin
      req_size[d] = 2'b00; req_addr[d] = 32'd0; req_wdata[d] = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 2'b00;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
      chk("reset_resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("reset_resp_fault", 32'(resp_fault[d]), 32'd0);
      chk("reset_resp_rdata", resp_rdata[d], 32'd0);
    end

    // Fill both stores so every byte is known to the model.
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 64; w++)
        txn(d, 1'b1, 2'b00, 32'(w * 4), $urandom, 0, r, f);

    // Word write and readback.
    txn(0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 0, r, f);
    chk("wr_word_fault", 32'(f), 32'd0);
    chk("wr_word_rdata", r, 32'd0);
    txn(0, 1'b0, 2'b00, 32'h10, 32'd0, 0, r, f);
    chk("rd_word", r, 32'hDEADBEEF);

    // Byte write, then mixed-width reads.
    txn(0, 1'b1, 2'b10, 32'h11, 32'h5A5A5AAB, 0, r, f);
    txn(0, 1'b0, 2'b00, 32'h10, 32'd0, 0, r, f);
    chk("rd_word_after_byte", r, 32'hDEADABEF);
    txn(0, 1'b0, 2'b01, 32'h12, 32'd0, 0, r, f);
    chk("rd_half", r, 32'h0000DEAD);
    txn(0, 1'b0, 2'b10, 32'h13, 32'd0, 0, r, f);
    chk("rd_byte", r, 32'h000000DE);

    // Faults.
    txn(0, 1'b0, 2'b00, 32'h12, 32'd0, 0, r, f);
    chk("flt_misword", 32'(f), 32'd1);
    chk("flt_misword_rdata", r, 32'd0);
    txn(0, 1'b1, 2'b01, 32'h13, 32'h1234, 0, r, f);
    chk("flt_mishalf", 32'(f), 32'd1);
    txn(0, 1'b0, 2'b00, 32'h10, 32'd0, 0, r, f);
    chk("flt_no_write", r, 32'hDEADABEF);
    txn(0, 1'b0, 2'b00, 32'h100, 32'd0, 0, r, f);
    chk("flt_range", 32'(f), 32'd1);
    txn(0, 1'b0, 2'b11, 32'h10, 32'd0, 0, r, f);
    chk("flt_size", 32'(f), 32'd1);

    // Backpressure for 5 cycles.
    txn(0, 1'b0, 2'b00, 32'h10, 32'd0, 5, r, f);
    chk("bp_rdata", r, 32'hDEADABEF);

    // Zero wait states: single transaction, then continuous throughput.
    txn(1, 1'b0, 2'b10, 32'h41, 32'd0, 0, r, f);
    model_txn(1, 1'b0, 2'b00, 32'h40, 32'd0, ef, erd);
    @(negedge clk);
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_size[1] = 2'b00;
    req_addr[1] = 32'h40; resp_ready[1] = 1'b1;
    prev = -1;
    cnt  = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (resp_valid[1] === 1'b1) begin
        chk("tp_rdata", resp_rdata[1], erd);
        if (prev >= 0) chk("tp_period", 32'(c - prev), 32'd3);
        prev = c;
        cnt++;
      end
    end
    chk("tp_count", 32'(cnt), 32'd10);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (4) @(posedge clk);

    // Reset while busy (mid-count and on the commit edge).
    reset_mid(0, 32'h20, 32'h11111111, 1);
    txn(0, 1'b0, 2'b00, 32'h20, 32'd0, 0, r, f);
    reset_mid(0, 32'h24, 32'h22222222, 3);
    txn(0, 1'b0, 2'b00, 32'h24, 32'd0, 0, r, f);
    reset_mid(1, 32'h20, 32'h33333333, 1);
    txn(1, 1'b0, 2'b00, 32'h20, 32'd0, 0, r, f);

    // Randomized traffic against the model.
    for (int i = 0; i < 150; i++) begin
      int          d;
      bit          wr;
      logic [1:0]  sz;
      logic [31:0] a;
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom);
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 255);
      txn(d, wr, sz, a, $urandom, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, r, f);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
